// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching, maskable, fixed-priority interrupt controller.
// It hands a per-source vector to instruction fetch through a req/ack handshake.
// It saves the interrupted PC, and mret restores the global enable saved on acknowledge.
module irq_ctrl #(
    parameter int unsigned NUM_IRQ  = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    input  logic               stall,
    input  logic [31:0]        current_pc,
    input  logic               irq_ack,
    input  logic               mret,
    output logic               irq_req,
    output logic [31:0]        irq_vector,
    output logic [31:0]        epc,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] prev, pending, ie;
    logic               gie, pgie;
    logic [3:0]         act_id, win_id;
    logic [NUM_IRQ-1:0] masked, rise, wclr, ack_clr;
    logic               launch, take_ack, do_mret;
    logic               unused_wdata;

    assign masked       = pending & ie;
    assign rise         = irq_src & ~prev;
    assign wclr         = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_IRQ-1:0] : '0;
    assign unused_wdata = ^cfg_wdata;

    // Lowest-index enabled pending source wins.
    always_comb begin
        logic found;
        found  = 1'b0;
        win_id = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found && masked[i]) begin
                win_id = 4'(i);
                found  = 1'b1;
            end
        end
    end

    // One-hot clear of the serviced source's pending bit on acknowledge.
    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = take_ack && (act_id == 4'(i));
        end
    end

    // Next-state logic and handshake event decode.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        take_ack  = 1'b0;
        do_mret   = 1'b0;
        case (state)
            IDLE: begin
                if (gie && (|masked) && !stall) begin
                    launch    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (mret) begin
                    do_mret   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Edge history, pending bits and software-visible config; a new edge beats any clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            pending <= '0;
            ie      <= '0;
            gie     <= 1'b0;
            pgie    <= 1'b0;
        end else begin
            prev    <= irq_src;
            pending <= (pending & ~wclr & ~ack_clr) | rise;
            if (cfg_we && cfg_addr == 2'd0) ie <= cfg_wdata[NUM_IRQ-1:0];
            if (cfg_we && cfg_addr == 2'd2) gie <= cfg_wdata[0];
            // Handshake events override a same-cycle CTRL write.
            if (take_ack) begin
                pgie <= gie;
                gie  <= 1'b0;
            end
            if (do_mret) gie <= pgie;
        end
    end

    // Registered handshake outputs, saved PC and active id.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_req    <= 1'b0;
            irq_vector <= VEC_BASE;
            epc        <= '0;
            in_service <= 1'b0;
            act_id     <= '0;
        end else begin
            if (launch) begin
                irq_req    <= 1'b1;
                irq_vector <= VEC_BASE + 32'({win_id, 2'b00});
                act_id     <= win_id;
            end
            if (take_ack) begin
                irq_req    <= 1'b0;
                in_service <= 1'b1;
                epc        <= current_pc;
            end
            if (do_mret) in_service <= 1'b0;
        end
    end

    // Combinational register read; unused bits are zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[NUM_IRQ-1:0] = ie;
            2'd1: cfg_rdata[NUM_IRQ-1:0] = pending;
            2'd2: cfg_rdata[0]           = gie;
            default: begin
                cfg_rdata[0]   = in_service;
                cfg_rdata[7:4] = act_id;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus random traffic, checked against a behavioural model.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] pc;
    logic        ack;
    logic        mret;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic [31:0] epc;
    logic        in_service;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [3:0]  m_prev, m_pending, m_ie, m_id;
    logic        m_gie, m_pgie, m_req, m_serv;
    logic [31:0] m_vec, m_epc;

    irq_ctrl #(.NUM_IRQ(4), .VEC_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .irq_src(src), .cfg_we(we), .cfg_addr(addr),
        .cfg_wdata(wdata), .cfg_rdata(rdata), .stall(stall), .current_pc(pc),
        .irq_ack(ack), .mret(mret), .irq_req(irq_req), .irq_vector(irq_vector),
        .epc(epc), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_prev = '0; m_pending = '0; m_ie = '0; m_id = '0;
        m_gie = 0; m_pgie = 0; m_req = 0; m_serv = 0;
        m_vec = BASE; m_epc = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[3:0] = m_ie;
            2'd1: r[3:0] = m_pending;
            2'd2: r[0]   = m_gie;
            default: begin r[0] = m_serv; r[7:4] = m_id; end
        endcase
        return r;
    endfunction

    // Apply one rising edge of the rules to the model using the currently driven inputs.
    task automatic m_edge();
        logic [3:0] rise, cand;
        logic       launch, ackev, mretev, old_gie;
        int         win;
        rise    = src & ~m_prev;
        m_prev  = src;
        cand    = m_pending & m_ie;
        old_gie = m_gie;
        launch  = !m_req && !m_serv && m_gie && (cand != 0) && !stall;
        ackev   = m_req && ack;
        mretev  = m_serv && mret;
        if (we && addr == 2'd0) m_ie = wdata[3:0];
        if (we && addr == 2'd1) m_pending = m_pending & ~wdata[3:0];
        if (we && addr == 2'd2) m_gie = wdata[0];
        if (ackev) begin
            m_epc = pc;
            m_pending[m_id] = 1'b0;
            m_pgie = old_gie;
            m_gie = 1'b0;
            m_req = 1'b0;
            m_serv = 1'b1;
        end
        if (mretev) begin
            m_gie = m_pgie;
            m_serv = 1'b0;
        end
        if (launch) begin
            win = -1;
            for (int i = 0; i < 4; i++) if (win < 0 && cand[i]) win = i;
            m_id  = 4'(win);
            m_req = 1'b1;
            m_vec = BASE + 32'(4 * win);
        end
        m_pending = m_pending | rise;
    endtask

    // One clock: edge, model update, compare on the falling edge, then drop one-cycle strobes.
    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("irq_req", 32'(irq_req), 32'(m_req));
        chk("irq_vector", irq_vector, m_vec);
        chk("epc", epc, m_epc);
        chk("in_service", 32'(in_service), 32'(m_serv));
        chk("cfg_rdata", rdata, m_read(addr));
        we = 0; ack = 0; mret = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1; addr = a; wdata = d;
        step();
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        reset = 0; src = 0; we = 0; addr = 0; wdata = 0; stall = 0; pc = 0; ack = 0; mret = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(irq_req), 32'h0);
        chk("rst_vec", irq_vector, 32'h100);
        chk("rst_epc", epc, 32'h0);
        for (int a = 0; a < 4; a++) rd_chk("rst_reg", 2'(a), 32'h0);
        reset = 1;

        // Basic timer interrupt.
        wr(2'd0, 32'h1);
        wr(2'd2, 32'h1);
        pc = 32'h40; src = 4'h1;
        step();
        chk("timer_no_req_yet", 32'(irq_req), 32'h0);
        src = 4'h0;
        step();
        chk("timer_req", 32'(irq_req), 32'h1);
        chk("timer_vec", irq_vector, 32'h100);
        ack = 1; addr = 2'd1;
        step();
        chk("ack_epc", epc, 32'h40);
        chk("ack_serv", 32'(in_service), 32'h1);
        rd_chk("ack_pending", 2'd1, 32'h0);
        rd_chk("ack_gie", 2'd2, 32'h0);
        mret = 1;
        step();
        rd_chk("mret_gie", 2'd2, 32'h1);
        chk("mret_serv", 32'(in_service), 32'h0);
        chk("mret_epc_hold", epc, 32'h40);

        // Priority: sources 3 and 1 together.
        wr(2'd0, 32'hF);
        src = 4'b1010;
        step();
        src = 4'h0;
        step();
        chk("prio_vec1", irq_vector, 32'h104);
        ack = 1; step();
        mret = 1; step();
        step();
        chk("prio_req2", 32'(irq_req), 32'h1);
        chk("prio_vec2", irq_vector, 32'h10C);
        ack = 1; step();
        mret = 1; step();

        // Masking, then stall holding off the request.
        wr(2'd0, 32'h0);
        src = 4'h4; step();
        src = 4'h0; step();
        rd_chk("mask_pending", 2'd1, 32'h4);
        chk("mask_no_req", 32'(irq_req), 32'h0);
        stall = 1;
        wr(2'd0, 32'h4);
        repeat (3) step();
        chk("stall_no_req", 32'(irq_req), 32'h0);
        stall = 0;
        step();
        chk("stall_release_req", 32'(irq_req), 32'h1);
        chk("stall_vec", irq_vector, 32'h108);

        // Held request: software clears PENDING, IE and GIE while REQ is up.
        wr(2'd1, 32'hF);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h0);
        chk("held_req", 32'(irq_req), 32'h1);
        chk("held_vec", irq_vector, 32'h108);
        pc = 32'h1234; ack = 1; step();
        mret = 1; step();
        rd_chk("held_gie_restored0", 2'd2, 32'h0);

        // Write-1-clear colliding with a new edge on the same bit.
        src = 4'h2; step();
        src = 4'h0; step();
        src = 4'h2; we = 1; addr = 2'd1; wdata = 32'h2;
        step();
        rd_chk("collide_pending", 2'd1, 32'h2);
        src = 4'h0;
        wr(2'd1, 32'hF);

        // Level source held high: one pending set only.
        src = 4'h1;
        repeat (10) step();
        rd_chk("level_pending", 2'd1, 32'h1);
        src = 4'h0;
        wr(2'd1, 32'hF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) src = 4'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            pc    = $urandom;
            ack   = m_req && ($urandom_range(0, 1) == 0);
            mret  = ($urandom_range(0, 4) == 0);
            we    = ($urandom_range(0, 4) == 0);
            addr  = 2'($urandom);
            wdata = $urandom;
            if (we && addr == 2'd2) wdata[0] = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset asserted while a handler is running.
        src = 4'h0; stall = 0;
        wr(2'd0, 32'hF);
        wr(2'd2, 32'h1);
        wr(2'd1, 32'hF);
        src = 4'h8; step();
        src = 4'h0; step();
        pc = 32'hCAFE; ack = 1; step();
        chk("pre_rst_serv", 32'(in_service), 32'h1);
        #2 reset = 0;
        #1;
        m_reset();
        chk("async_rst_req", 32'(irq_req), 32'h0);
        chk("async_rst_serv", 32'(in_service), 32'h0);
        chk("async_rst_epc", epc, 32'h0);
        chk("async_rst_vec", irq_vector, 32'h100);
        for (int a = 0; a < 4; a++) rd_chk("async_rst_reg", 2'(a), 32'h0);
        @(negedge clk);
        reset = 1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the RV32I microcontroller. It sits between the interrupt sources and the instruction-fetch stage. Bit 0 of its source vector is the timer unit's `timer_interrupt`. It latches rising edges into pending bits, masks and prioritises them, and runs a request/acknowledge handshake with fetch to redirect the PC to a per-source vector. It saves the interrupted PC and restores global enable on `mret`. Software configures it through a small register port driven by the datapath.

## Interface
- `NUM_IRQ`, default 4: number of sources, legal range 1–16.
- `VEC_BASE`, default 32'h0000_0100: vector for source 0. Source `i` vectors to `VEC_BASE + 4*i`.

- `clk` in 1: system clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `irq_src` in NUM_IRQ: interrupt sources, synchronous to `clk`. Bit 0 = timer.
- `cfg_we` in 1: register write strobe.
- `cfg_addr` in 2: register select.
- `cfg_wdata` in 32: register write data.
- `cfg_rdata` out 32: register read data, combinational from `cfg_addr`.
- `stall` in 1: pipeline stall. No new request is raised while high.
- `current_pc` in 32: PC to resume at, sampled on acknowledge.
- `irq_ack` in 1: fetch has taken `irq_vector`.
- `mret` in 1: return-from-interrupt executed, one-cycle pulse.
- `irq_req` out 1: interrupt request to fetch.
- `irq_vector` out 32: target PC, valid while `irq_req` is high.
- `epc` out 32: saved return PC.
- `in_service` out 1: a handler is running.

## Operation
- **Register map**
  - 0 `IE`: enable mask, read/write, bits [NUM_IRQ-1:0].
  - 1 `PENDING`: read; writing 1 to a bit clears it.
  - 2 `CTRL`: bit 0 = `GIE` (global enable), read/write.
  - 3 `STATUS`: read-only; bit 0 = `in_service`, bits [7:4] = active id.
  - Unused bits read 0.
- **Edge detect:** `prev` register per source. A bit of `PENDING` is set when `irq_src[i]=1` and `prev[i]=0`.
- **Pending set vs clear:**
  - Pending sets regardless of `IE`; `IE` only gates request generation.
  - Set and write-1-clear on the same bit in the same cycle: set wins.
- **Priority:** among `PENDING & IE`, the lowest index wins.
- **FSM states:** IDLE, REQ, SERVICE.
- **IDLE → REQ** when `GIE=1`, `PENDING & IE` is nonzero and `stall=0`.
  - Latch the winning id.
  - Register `irq_req=1` and `irq_vector=VEC_BASE + 4*id`.
- **REQ:**
  - `irq_req` and `irq_vector` are held stable until `irq_ack`.
  - The request is committed: clearing `PENDING`/`IE`/`GIE` by software in this state does not withdraw it.
  - On `irq_ack`:
    - `epc <= current_pc`;
    - clear `PENDING[id]` (a same-cycle new edge on that source re-sets it);
    - save `GIE` into `PGIE`, force `GIE=0`;
    - `irq_req <= 0`, `in_service <= 1`;
    - go to SERVICE.
- **SERVICE:**
  - No nesting; new edges only accumulate in `PENDING`.
  - On `mret`: `GIE <= PGIE`, `in_service <= 0`, go to IDLE. `epc` holds its value.
- **Ignored inputs:** `mret` in IDLE or REQ is ignored. `irq_ack` outside REQ is ignored.
- **Reset values:**
  - `irq_req=0`, `irq_vector=VEC_BASE`, `epc=0`, `in_service=0`.
  - `IE`, `PENDING`, `GIE`, `PGIE`, `prev` = 0.
  - FSM in IDLE.

## Timing
- **Source edge to pending:** `irq_src` rises and is sampled at edge N. `PENDING` is set after edge N.
- **Pending to request:** with `GIE`, `IE` set and `stall=0`, `irq_req` goes high after edge N+1. Latency is two cycles from a sampled source edge.
- **Stall:** while `stall=1` in IDLE, the request is deferred. It rises one edge after `stall` falls.
- **Acknowledge:** `irq_ack` sampled high at edge M gives `irq_req=0`, `in_service=1` and `epc` valid after M. The earliest next request follows `mret` plus one edge.
- **Config writes:** take effect at the writing edge. A write enabling `GIE` with pending interrupts gives `irq_req` one edge later.
- **Reset mid-operation:** asynchronous assertion immediately drops `irq_req` and `in_service` and returns the FSM to IDLE. Release is synchronous to the next `clk`.

## Test plan
- **Basic timer interrupt:** `IE=1`, `GIE=1`, `current_pc=32'h40`; pulse `irq_src[0]`.
  - `irq_req` high 2 cycles later with `irq_vector=32'h100`.
  - Ack → `epc=32'h40`, `PENDING=0`, `GIE=0`, `in_service=1`.
  - `mret` → `GIE=1`, `in_service=0`.
- **Priority:** edges on `irq_src[3]` and `irq_src[1]` in the same cycle, `IE=4'hF`.
  - Vector `32'h104` first; after `mret`, vector `32'h10C`.
- **Masking and stall:**
  - Edge on `irq_src[2]` with `IE=0` → `PENDING=4'h4` and no request; writing `IE=4` then raises the request.
  - With `stall=1` the request is held off until `stall=0`.
- **Held request and collisions:**
  - During REQ, software clears `PENDING` and `GIE` → `irq_req` and `irq_vector` stay stable until ack.
  - Write-1-clear colliding with a new edge → bit remains 1.
- **Level source and reset:**
  - `irq_src[0]` held high for 10 cycles → exactly one pending set.
  - Reset asserted in SERVICE → `irq_req=0`, `in_service=0`, `epc=0`, all registers 0.
